// File: rtl/tile_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : tile_sched_if
// Brief   : Tile handshake, ctr_gen strobe and result bundle around tile_sched.
// Revision: 1.0
// ============================================================================
interface tile_sched_if #(
    parameter int CNT_W    = 16,
    parameter int LOG2_PES = 5
);
    logic                w_tile_valid;
    logic [LOG2_PES:0]   w_tile_nnz;
    logic                w_tile_ready;
    logic                i_tile_valid;
    logic                i_tile_ready;
    logic                ctr_w_valid;
    logic                ctr_i_valid;
    logic                done_computing_one_tile;
    logic                out_valid;
    logic [CNT_W-1:0]    out_w_idx;
    logic [CNT_W-1:0]    out_i_idx;
    logic                out_zero;

    // Environment side: tile fetch unit plus datapath
    modport master (
        output w_tile_valid, w_tile_nnz, i_tile_valid, done_computing_one_tile,
        input  w_tile_ready, i_tile_ready, ctr_w_valid, ctr_i_valid,
        input  out_valid, out_w_idx, out_i_idx, out_zero
    );

    // Scheduler side
    modport slave (
        input  w_tile_valid, w_tile_nnz, i_tile_valid, done_computing_one_tile,
        output w_tile_ready, i_tile_ready, ctr_w_valid, ctr_i_valid,
        output out_valid, out_w_idx, out_i_idx, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/tile_sched.sv
`default_nettype none
// ============================================================================
// Module  : tile_sched
// Brief   : Weight-outer / input-inner tile loop scheduler feeding ctr_gen.
//           Optional compute watchdog enabled by defining TILE_SCHED_WDOG_EN.
// Revision: 1.0
// ============================================================================
module tile_sched #(
    parameter int NUM_PES     = 32,
    parameter int LOG2_PES    = 5,
    parameter int CNT_W       = 16,
    parameter int FILL_CYCLES = 2,
    parameter int WDOG_CYCLES = 1024
) (
    input  wire                clk,
    input  wire                rst,
    input  wire                start,
    input  wire [CNT_W-1:0]    cfg_num_w_tiles,
    input  wire [CNT_W-1:0]    cfg_num_i_tiles,
    tile_sched_if.slave        bus,
    output logic               busy,
    output logic               done,
    output logic               err_ovf
`ifdef TILE_SCHED_WDOG_EN
    ,
    output logic               wdog_err
`endif
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_W_WAIT  = 3'd1;
    localparam logic [2:0] c_W_FILL  = 3'd2;
    localparam logic [2:0] c_I_WAIT  = 3'd3;
    localparam logic [2:0] c_COMPUTE = 3'd4;
    localparam logic [2:0] c_ERR     = 3'd5;

    localparam int              c_FILL_W    = (FILL_CYCLES < 1) ? 1 : $clog2(FILL_CYCLES + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_INIT = c_FILL_W'(FILL_CYCLES);
    localparam logic [c_FILL_W-1:0] c_FILL_ONE  = c_FILL_W'(1);
    localparam logic [LOG2_PES:0]   c_MAX_NNZ   = (LOG2_PES + 1)'(NUM_PES);
    localparam logic [CNT_W-1:0]    c_IDX_ONE   = CNT_W'(1);

    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_num_w;
    logic [CNT_W-1:0]     r_num_i;
    logic [CNT_W-1:0]     r_w_idx;
    logic [CNT_W-1:0]     r_i_idx;
    logic [LOG2_PES:0]    r_nnz;
    logic [c_FILL_W-1:0]  r_fill;
    logic                 r_ctr_w_valid;
    logic                 r_ctr_i_valid;
    logic                 r_out_valid;
    logic [CNT_W-1:0]     r_out_w_idx;
    logic [CNT_W-1:0]     r_out_i_idx;
    logic                 r_out_zero;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err_ovf;

    logic                 w_last_i;
    logic                 w_last_w;
    logic                 w_zero_skip;
    logic                 w_advance;

`ifdef TILE_SCHED_WDOG_EN
    localparam int                  c_WDOG_W    = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_CYCLES - 1);
    logic [c_WDOG_W-1:0]  r_wdog_cnt;
    logic                 r_wdog_err;
`endif

    // Ready depends only on state so upstream can never see a combinational loop
    assign bus.w_tile_ready = (r_state == c_W_WAIT);
    assign bus.i_tile_ready = (r_state == c_I_WAIT);
    assign bus.ctr_w_valid  = r_ctr_w_valid;
    assign bus.ctr_i_valid  = r_ctr_i_valid;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_w_idx    = r_out_w_idx;
    assign bus.out_i_idx    = r_out_i_idx;
    assign bus.out_zero     = r_out_zero;
    assign busy             = r_busy;
    assign done             = r_done;
    assign err_ovf          = r_err_ovf;
`ifdef TILE_SCHED_WDOG_EN
    assign wdog_err         = r_wdog_err;
`endif

    assign w_last_i    = (r_i_idx == (r_num_i - c_IDX_ONE));
    assign w_last_w    = (r_w_idx == (r_num_w - c_IDX_ONE));
    assign w_zero_skip = (r_state == c_I_WAIT) && bus.i_tile_valid && (r_nnz == '0);
    assign w_advance   = w_zero_skip ||
                         ((r_state == c_COMPUTE) && bus.done_computing_one_tile);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_IDLE;
            r_num_w       <= '0;
            r_num_i       <= '0;
            r_w_idx       <= '0;
            r_i_idx       <= '0;
            r_nnz         <= '0;
            r_fill        <= '0;
            r_ctr_w_valid <= 1'b0;
            r_ctr_i_valid <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_w_idx   <= '0;
            r_out_i_idx   <= '0;
            r_out_zero    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_ovf     <= 1'b0;
`ifdef TILE_SCHED_WDOG_EN
            r_wdog_cnt    <= '0;
            r_wdog_err    <= 1'b0;
`endif
        end else begin
            r_ctr_w_valid <= 1'b0;
            r_ctr_i_valid <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_zero    <= 1'b0;
            r_done        <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if ((cfg_num_w_tiles != '0) && (cfg_num_i_tiles != '0)) begin
                            r_num_w <= cfg_num_w_tiles;
                            r_num_i <= cfg_num_i_tiles;
                            r_w_idx <= '0;
                            r_i_idx <= '0;
                            r_busy  <= 1'b1;
                            r_state <= c_W_WAIT;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_W_WAIT: begin
                    if (bus.w_tile_valid) begin
                        r_nnz <= bus.w_tile_nnz;
                        if (bus.w_tile_nnz > c_MAX_NNZ) begin
                            r_err_ovf <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= c_ERR;
                        end else begin
                            r_ctr_w_valid <= 1'b1;
                            r_fill        <= c_FILL_INIT;
                            r_state       <= c_W_FILL;
                        end
                    end
                end
                c_W_FILL: begin
                    r_fill <= r_fill - c_FILL_ONE;
                    if (r_fill <= c_FILL_ONE) begin
                        r_state <= c_I_WAIT;
                    end
                end
                c_I_WAIT: begin
                    // Empty weight tiles are reported directly by the advance path below
                    if (bus.i_tile_valid && (r_nnz != '0)) begin
                        r_ctr_i_valid <= 1'b1;
                        r_state       <= c_COMPUTE;
`ifdef TILE_SCHED_WDOG_EN
                        r_wdog_cnt    <= '0;
`endif
                    end
                end
                c_COMPUTE: begin
`ifdef TILE_SCHED_WDOG_EN
                    if (!bus.done_computing_one_tile) begin
                        if (r_wdog_cnt == c_WDOG_LAST) begin
                            r_wdog_err <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= c_ERR;
                        end else begin
                            r_wdog_cnt <= r_wdog_cnt + 1'b1;
                        end
                    end
`endif
                end
                c_ERR: begin
                    r_state <= c_ERR;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            if (w_advance) begin
                r_out_valid <= 1'b1;
                r_out_zero  <= w_zero_skip;
                r_out_w_idx <= r_w_idx;
                r_out_i_idx <= r_i_idx;
                if (!w_last_i) begin
                    r_i_idx <= r_i_idx + c_IDX_ONE;
                    r_state <= c_I_WAIT;
                end else begin
                    r_i_idx <= '0;
                    if (!w_last_w) begin
                        r_w_idx <= r_w_idx + c_IDX_ONE;
                        r_state <= c_W_WAIT;
                    end else begin
                        r_w_idx <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
